// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM states and cycle-type codes.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_wdog.sv
// Stall watchdog: expires on the WDOG-th consecutive enabled cycle.
module wb_wdog #(
    parameter int WDOG = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt_q;

    // cnt_q holds the stalls already seen, so this cycle is stall WDOG
    assign expire = en && (cnt_q == 8'(WDOG - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || expire) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter with a stall watchdog.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int ADR_W = 32,
    parameter int DAT_W = 32,
    parameter int WDOG  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               m0_cyc,
    input  logic               m0_stb,
    input  logic               m0_we,
    input  logic [DAT_W/8-1:0] m0_sel,
    input  logic [ADR_W-1:0]   m0_adr,
    input  logic [DAT_W-1:0]   m0_dat_ms,
    input  logic [2:0]         m0_cti,
    output logic               m0_ack,
    output logic               m0_err,
    output logic [DAT_W-1:0]   m0_dat_sm,
    input  logic               m1_cyc,
    input  logic               m1_stb,
    input  logic               m1_we,
    input  logic [DAT_W/8-1:0] m1_sel,
    input  logic [ADR_W-1:0]   m1_adr,
    input  logic [DAT_W-1:0]   m1_dat_ms,
    input  logic [2:0]         m1_cti,
    output logic               m1_ack,
    output logic               m1_err,
    output logic [DAT_W-1:0]   m1_dat_sm,
    output logic               s_cyc,
    output logic               s_stb,
    output logic               s_we,
    output logic [DAT_W/8-1:0] s_sel,
    output logic [ADR_W-1:0]   s_adr,
    output logic [DAT_W-1:0]   s_dat_ms,
    output logic [2:0]         s_cti,
    input  logic               s_ack,
    input  logic [DAT_W-1:0]   s_dat_sm
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       lock_q, lock_d;
    logic       g_stb;
    logic       wd_en, wd_clr, expire;
    logic       req0, req1;

    assign g_stb = (state_q == GNT0) ? m0_stb :
                   (state_q == GNT1) ? m1_stb : 1'b0;

    assign wd_en  = g_stb & ~s_ack;
    assign wd_clr = s_ack | (state_q == IDLE) | (state_d != state_q);

    // a master that just timed out sits out one arbitration round
    assign req0 = m0_cyc & ~(lock_q & ~last_q);
    assign req1 = m1_cyc & ~(lock_q & last_q);

    wb_wdog #(
        .WDOG(WDOG)
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        lock_d  = lock_q;
        unique case (state_q)
            IDLE: begin
                lock_d = 1'b0;
                if (req0 && req1) begin
                    state_d = last_q ? GNT0 : GNT1;
                    last_d  = ~last_q;
                end else if (req0) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: begin
                if (expire) begin
                    state_d = IDLE;
                    lock_d  = 1'b1;
                end else if (!m0_cyc) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (expire) begin
                    state_d = IDLE;
                    lock_d  = 1'b1;
                end else if (!m1_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_sel     = '0;
        s_adr     = '0;
        s_dat_ms  = '0;
        s_cti     = '0;
        m0_ack    = 1'b0;
        m0_err    = 1'b0;
        m0_dat_sm = '0;
        m1_ack    = 1'b0;
        m1_err    = 1'b0;
        m1_dat_sm = '0;
        unique case (state_q)
            GNT0: begin
                s_cyc     = m0_cyc & ~expire;
                s_stb     = m0_stb & ~expire;
                s_we      = m0_we;
                s_sel     = m0_sel;
                s_adr     = m0_adr;
                s_dat_ms  = m0_dat_ms;
                s_cti     = m0_cti;
                m0_ack    = s_ack;
                m0_err    = expire;
                m0_dat_sm = s_dat_sm;
            end
            GNT1: begin
                s_cyc     = m1_cyc & ~expire;
                s_stb     = m1_stb & ~expire;
                s_we      = m1_we;
                s_sel     = m1_sel;
                s_adr     = m1_adr;
                s_dat_ms  = m1_dat_ms;
                s_cti     = m1_cti;
                m1_ack    = s_ack;
                m1_err    = expire;
                m1_dat_sm = s_dat_sm;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADR_W, 32, address width.
- DAT_W, 32, data width, a multiple of 8.
- WDOG, 64, cycles a granted master may wait without ack before error, 2..255.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock, all logic on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- mN_cyc, in, 1, N=0,1: master bus-cycle request.
- mN_stb, in, 1, master strobe.
- mN_we, in, 1, master write enable.
- mN_sel, in, DAT_W/8, master byte selects.
- mN_adr, in, ADR_W, master byte address.
- mN_dat_ms, in, DAT_W, master write data.
- mN_cti, in, 3, master cycle-type identifier.
- mN_ack, out, 1, ack routed to master N.
- mN_err, out, 1, watchdog error to master N.
- mN_dat_sm, out, DAT_W, read data to master N.
- s_cyc, s_stb, s_we, out, 1 each, shared-slave controls.
- s_sel, out, DAT_W/8, slave byte selects.
- s_adr, out, ADR_W, slave address.
- s_dat_ms, out, DAT_W, slave write data.
- s_cti, out, 3, slave cycle type.
- s_ack, in, 1, slave acknowledge.
- s_dat_sm, in, DAT_W, slave read data.

Function
REQ-003 FSM states are IDLE, GNT0 and GNT1, with the state registered.
REQ-004 In IDLE with one mN_cyc high, the FSM SHALL go to GNTN on the next edge; the grant latency is 1 cycle.
REQ-005 In IDLE with both cyc high, the FSM grants the master not granted last (round-robin); the last-granted bit resets to 1, so m0 wins the first tie.
REQ-006 In GNTN, all s_* outputs are driven from mN_*; in IDLE, s_cyc and s_stb are 0 and other s_* outputs are 0.
REQ-007 s_ack and s_dat_sm are routed combinationally to the granted master only; the non-granted master sees mN_ack=0 and mN_dat_sm=0.
REQ-008 The grant is held while mN_cyc=1, across any number of stb/ack beats and cti 001/010 bursts, and is never preempted.
REQ-009 When the granted mN_cyc falls, the FSM returns to IDLE; the next grant follows at least 1 cycle later, with no back-to-back handover.
REQ-010 Watchdog: a counter clears on every s_ack or grant change and increments each cycle while granted with s_stb=1 and s_ack=0.
REQ-011 When the counter reaches WDOG, mN_err pulses for 1 cycle, s_cyc and s_stb are forced to 0 that cycle, and the FSM goes to IDLE.
REQ-012 After a watchdog error, master N must drop cyc; while that master's cyc stays high it is not regranted until the other master has been served, or until 1 IDLE cycle if the other master is idle.
REQ-013 s_ack arriving while in IDLE is ignored.
REQ-014 Simultaneous s_ack and watchdog expiry: the ack wins, the counter clears and no err is raised.

Reset
REQ-015 While rst_n=0: state=IDLE, last-granted=1, counter=0, and all outputs 0.
REQ-016 Reset asserted mid-transaction SHALL drop s_cyc, s_stb and the ack paths immediately (asynchronously); no beat completes.

Structure
REQ-017 The FSM state enum and the cti constants (CLASSIC=000, CONST=001, INCR=010, EOB=111) SHALL reside in the shared package wb_pkg.
REQ-018 The design is a single module; the watchdog counter may be the sub-module wb_wdog (parameter WDOG, inputs clr and en, output expire).

Verification
REQ-019 m0 alone issues a classic write (adr 0x10, data 0xA5A5A5A5) -> grant after 1 cycle, s_adr=0x10, m0_ack equals s_ack, and m1_ack stays 0.
REQ-020 m0 and m1 raise cyc in the same cycle after reset -> m0 is served first, m1 is granted 1 cycle after m0_cyc falls, and a second tie goes to m0.
REQ-021 m1 runs a 4-beat incrementing read (cti 010,010,010,111) while m0 requests -> m1 keeps the grant for all 4 acks and m0 is granted afterwards.
REQ-022 With WDOG=8, the slave never acks -> m0_err pulses at the 8th stalled cycle, s_cyc drops that cycle, and the FSM returns to IDLE.
REQ-023 rst_n is pulled low mid-burst -> s_cyc=0 and mN_ack=0 immediately; after release, state=IDLE and m0 wins the next tie.
REQ-024 s_ack coincides with watchdog expiry -> no err and the transfer completes normally.
